mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM pipeline stage, including the MEM/WB pipeline register.
- Consumes EX/MEM control and data, and performs loads and stores over a request/acknowledge data-memory interface with variable latency.
- Stalls the upstream pipeline while an access is outstanding.
- Registers MemWB_readData, MemWB_ALUOut, MemWB_WB_MemToReg, RegWrite and rd for the writeback stage. WB selects readData when MemToReg=1, otherwise ALUOut.

Parameters:
- MEM_TIMEOUT, 16, maximum cycles waiting for dmem_ack before the access is abandoned (must be ≥ 2).
- CNT_W, 5, width of the timeout counter (must hold MEM_TIMEOUT).

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- ExMem_valid  in  1  EX/MEM holds a real instruction
- ExMem_MemRead  in  1  load
- ExMem_MemWrite  in  1  store
- ExMem_WB_MemToReg  in  1  passed to WB
- ExMem_WB_RegWrite  in  1  passed to WB
- ExMem_ALUOut  in  32  ALU result / memory address
- ExMem_writeData  in  32  store data
- ExMem_rd  in  5  destination register
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address, byte-addressed
- dmem_wdata  out  32  store data
- dmem_ack  in  1  access complete; rdata valid this cycle for loads
- dmem_rdata  in  32  load data
- Mem_stall  out  1  upstream must hold EX/MEM and not advance
- Mem_err  out  1  sticky error (misaligned or timeout); cleared only by rst
- MemWB_valid  out  1  WB holds a real instruction
- MemWB_WB_MemToReg  out  1
- MemWB_WB_RegWrite  out  1
- MemWB_readData  out  32
- MemWB_ALUOut  out  32
- MemWB_rd  out  5

Behaviour:
- Reset: state=IDLE, counter=0, all outputs 0 (including dmem_req, Mem_stall, Mem_err and all MemWB_* signals).
- A memory op is ExMem_valid & (MemRead | MemWrite). If both MemRead and MemWrite are 1, MemWrite wins.
- IDLE, non-memory op: the next edge loads the MemWB registers from EX/MEM, with readData=0. Latency is 1 cycle; Mem_stall stays 0.
- IDLE, ExMem_valid=0: the next edge writes a bubble (MemWB_valid=0, RegWrite=0).
- IDLE, memory op with ExMem_ALUOut[1:0] != 0:
  - No request is issued.
  - Next edge: bubble with RegWrite=0, and Mem_err is set.
  - No stall.
- IDLE, aligned memory op:
  - Mem_stall=1 combinationally in the same cycle.
  - Next edge: state→ACCESS; dmem_addr, dmem_wdata and dmem_we are registered from EX/MEM; counter=0; MemWB gets a bubble.
- ACCESS:
  - dmem_req=1, with address, data and we held stable.
  - Mem_stall = ~dmem_ack (combinational), so upstream advances in the ack cycle.
  - counter increments each cycle without ack.
- ACCESS with dmem_ack=1, next edge:
  - MemWB is loaded from EX/MEM plus readData=dmem_rdata. For stores, readData=0.
  - dmem_req drops to 0; state→IDLE.
  - Total load latency = 1 + (cycles until ack) + 1.
- ACCESS with counter = MEM_TIMEOUT-1 and no ack:
  - Next edge: state→IDLE, dmem_req=0, Mem_err set.
  - MemWB is loaded with valid=1, RegWrite=0 (instruction retired, no register write). Mem_stall drops in that cycle.
- Ack arriving in IDLE is ignored. Ack coincident with the timeout cycle counts as an ack.
- Reset during ACCESS: the next edge forces IDLE with dmem_req=0; a late ack is ignored.
- Back-to-back memory ops: after an ack, the following instruction is evaluated in IDLE on the next cycle. There is at most one outstanding request.
- EX/MEM inputs are sampled only in IDLE. Values held upstream during a stall are not re-sampled.

Decomposition:
- Shared package contains:
  - State encoding: IDLE=1'b0, ACCESS=1'b1.
  - Constant WORD_ALIGN_MASK=2'b11.
  - Data width 32 and register-index width 5.
- One sub-module, memwb_reg: the MEM/WB pipeline register with load/bubble controls and synchronous reset. The FSM, counter and dmem interface stay in mem_stage.

Test Plan:
- Non-memory op: valid, ALUOut=0x0000_0003, rd=7, RegWrite=1, MemToReg=0 → next cycle MemWB_valid=1, ALUOut=0x3, rd=7, RegWrite=1, no stall.
- Load at 0x0000_0010, ack 3 cycles after req, rdata=0x0000_0005 → req is held with addr=0x10 and we=0; Mem_stall is high until the ack cycle; cycle after ack: MemWB_readData=0x5, MemToReg=1.
- Store at 0x20, data 0xDEAD_BEEF, ack on first ACCESS cycle → dmem_we=1 and wdata=0xDEADBEEF for 1 cycle; MemWB_RegWrite=0; stall lasts 1 cycle.
- Misaligned load at 0x0000_0013 → no dmem_req; Mem_err=1 next cycle; MemWB bubble with RegWrite=0.
- No ack with MEM_TIMEOUT=16 → req high for 16 cycles, then drops; Mem_err=1; MemWB_valid=1 with RegWrite=0.
- rst asserted on the 2nd ACCESS cycle, ack 1 cycle later → all outputs 0 after the rst edge; the late ack produces no MemWB update.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
// Holds the FSM state encoding, the alignment mask and the datapath widths.
package mem_stage_pkg;

    localparam int unsigned DataW = 32;
    localparam int unsigned RegW  = 5;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    typedef enum logic {
        StIdle   = 1'b0,
        StAccess = 1'b1
    } state_e;

    function automatic logic is_word_aligned(input logic [DataW-1:0] addr);
        return (addr[1:0] & WORD_ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Request/acknowledge data-memory bus between the MEM stage (master) and memory (slave).
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic             dmem_req;
    logic             dmem_we;
    logic [DataW-1:0] dmem_addr;
    logic [DataW-1:0] dmem_wdata;
    logic             dmem_ack;
    logic [DataW-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/mem_stage_memwb_reg.sv
// MEM/WB pipeline register: load captures the inputs, bubble clears it, otherwise it holds.
module memwb_reg
    import mem_stage_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             bubble_i,
    input  logic             valid_i,
    input  logic             mem_to_reg_i,
    input  logic             reg_write_i,
    input  logic [DataW-1:0] alu_out_i,
    input  logic [DataW-1:0] read_data_i,
    input  logic [RegW-1:0]  rd_i,
    output logic             valid_o,
    output logic             mem_to_reg_o,
    output logic             reg_write_o,
    output logic [DataW-1:0] alu_out_o,
    output logic [DataW-1:0] read_data_o,
    output logic [RegW-1:0]  rd_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i || (bubble_i && !load_i)) begin
            valid_o      <= 1'b0;
            mem_to_reg_o <= 1'b0;
            reg_write_o  <= 1'b0;
            alu_out_o    <= '0;
            read_data_o  <= '0;
            rd_o         <= '0;
        end else if (load_i) begin
            valid_o      <= valid_i;
            mem_to_reg_o <= mem_to_reg_i;
            reg_write_o  <= reg_write_i;
            alu_out_o    <= alu_out_i;
            read_data_o  <= read_data_i;
            rd_o         <= rd_i;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one load/store at a time over a req/ack bus with timeout,
// stalls upstream while the access is outstanding and feeds the MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ExMem_valid_i,
    input  logic             ExMem_MemRead_i,
    input  logic             ExMem_MemWrite_i,
    input  logic             ExMem_WB_MemToReg_i,
    input  logic             ExMem_WB_RegWrite_i,
    input  logic [DataW-1:0] ExMem_ALUOut_i,
    input  logic [DataW-1:0] ExMem_writeData_i,
    input  logic [RegW-1:0]  ExMem_rd_i,
    mem_stage_if.master      dmem,
    output logic             Mem_stall_o,
    output logic             Mem_err_o,
    output logic             MemWB_valid_o,
    output logic             MemWB_WB_MemToReg_o,
    output logic             MemWB_WB_RegWrite_o,
    output logic [DataW-1:0] MemWB_readData_o,
    output logic [DataW-1:0] MemWB_ALUOut_o,
    output logic [RegW-1:0]  MemWB_rd_o
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             req_q, we_q, err_q;
    logic [DataW-1:0] addr_q, wdata_q;
    // WB controls captured at issue so completion never re-reads the held EX/MEM values.
    logic             mem_to_reg_q, reg_write_q;
    logic [RegW-1:0]  rd_q;

    logic             mem_op, aligned, timeout;
    logic             wb_load, wb_valid, wb_m2r, wb_rw;
    logic [DataW-1:0] wb_alu, wb_rdata;
    logic [RegW-1:0]  wb_rd;

    assign mem_op  = ExMem_valid_i & (ExMem_MemRead_i | ExMem_MemWrite_i);
    assign aligned = is_word_aligned(ExMem_ALUOut_i);
    assign timeout = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        wb_load     = 1'b0;
        wb_valid    = 1'b0;
        wb_m2r      = 1'b0;
        wb_rw       = 1'b0;
        wb_alu      = '0;
        wb_rdata    = '0;
        wb_rd       = '0;
        Mem_stall_o = 1'b0;
        if (state_q == StIdle) begin
            if (ExMem_valid_i && !mem_op) begin
                wb_load  = 1'b1;
                wb_valid = 1'b1;
                wb_m2r   = ExMem_WB_MemToReg_i;
                wb_rw    = ExMem_WB_RegWrite_i;
                wb_alu   = ExMem_ALUOut_i;
                wb_rd    = ExMem_rd_i;
            end else if (mem_op && aligned) begin
                Mem_stall_o = 1'b1;
            end
        end else begin
            Mem_stall_o = ~dmem.dmem_ack & ~timeout;
            if (dmem.dmem_ack || timeout) begin
                wb_load  = 1'b1;
                wb_valid = 1'b1;
                wb_m2r   = mem_to_reg_q;
                wb_rw    = dmem.dmem_ack & reg_write_q;
                wb_alu   = addr_q;
                wb_rd    = rd_q;
                wb_rdata = (dmem.dmem_ack && !we_q) ? dmem.dmem_rdata : '0;
            end
        end
        if (rst_i) Mem_stall_o = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            rd_q         <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mem_op && aligned) begin
                        state_q      <= StAccess;
                        cnt_q        <= '0;
                        req_q        <= 1'b1;
                        we_q         <= ExMem_MemWrite_i;
                        addr_q       <= ExMem_ALUOut_i;
                        wdata_q      <= ExMem_writeData_i;
                        mem_to_reg_q <= ExMem_WB_MemToReg_i;
                        reg_write_q  <= ExMem_WB_RegWrite_i;
                        rd_q         <= ExMem_rd_i;
                    end else if (mem_op) begin
                        err_q <= 1'b1;
                    end
                end
                StAccess: begin
                    if (dmem.dmem_ack || timeout) begin
                        state_q <= StIdle;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        if (!dmem.dmem_ack) err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign Mem_err_o       = err_q;

    memwb_reg u_memwb_reg (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_i       (wb_load),
        .bubble_i     (~wb_load),
        .valid_i      (wb_valid),
        .mem_to_reg_i (wb_m2r),
        .reg_write_i  (wb_rw),
        .alu_out_i    (wb_alu),
        .read_data_i  (wb_rdata),
        .rd_i         (wb_rd),
        .valid_o      (MemWB_valid_o),
        .mem_to_reg_o (MemWB_WB_MemToReg_o),
        .reg_write_o  (MemWB_WB_RegWrite_o),
        .alu_out_o    (MemWB_ALUOut_o),
        .read_data_o  (MemWB_readData_o),
        .rd_o         (MemWB_rd_o)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, load, store, misalignment, timeout, reset abort.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             ex_valid, ex_rd_en, ex_wr_en, ex_m2r, ex_rw;
    logic [31:0]      ex_alu, ex_wdata;
    logic [4:0]       ex_rd;
    logic             stall, err, wb_valid, wb_m2r, wb_rw;
    logic [31:0]      wb_rdata, wb_alu;
    logic [4:0]       wb_rd;
    int unsigned      n_cmp = 0;
    int unsigned      n_err = 0;
    int unsigned      req_cycles;

    mem_stage_if bus ();

    always #5 clk = ~clk;

    mem_stage #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .ExMem_valid_i       (ex_valid),
        .ExMem_MemRead_i     (ex_rd_en),
        .ExMem_MemWrite_i    (ex_wr_en),
        .ExMem_WB_MemToReg_i (ex_m2r),
        .ExMem_WB_RegWrite_i (ex_rw),
        .ExMem_ALUOut_i      (ex_alu),
        .ExMem_writeData_i   (ex_wdata),
        .ExMem_rd_i          (ex_rd),
        .dmem                (bus.master),
        .Mem_stall_o         (stall),
        .Mem_err_o           (err),
        .MemWB_valid_o       (wb_valid),
        .MemWB_WB_MemToReg_o (wb_m2r),
        .MemWB_WB_RegWrite_o (wb_rw),
        .MemWB_readData_o    (wb_rdata),
        .MemWB_ALUOut_o      (wb_alu),
        .MemWB_rd_o          (wb_rd)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic r, input logic w, input logic m2r,
                          input logic rw, input logic [31:0] alu, input logic [31:0] wd,
                          input logic [4:0] rd);
        ex_valid = v; ex_rd_en = r; ex_wr_en = w; ex_m2r = m2r; ex_rw = rw;
        ex_alu = alu; ex_wdata = wd; ex_rd = rd;
    endtask

    initial begin
        rst = 1'b1;
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = '0;
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        @(negedge clk);
        check_eq("rst_req", bus.dmem_req, 0);
        check_eq("rst_stall", stall, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_wb_valid", wb_valid, 0);
        check_eq("rst_wb_rw", wb_rw, 0);
        tick();
        rst = 1'b0;

        // Non-memory op passes straight through in one cycle.
        set_ex(1, 0, 0, 0, 1, 32'h3, 0, 5'd7);
        @(negedge clk);
        check_eq("alu_stall", stall, 0);
        tick();
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_eq("alu_wb_valid", wb_valid, 1);
        check_eq("alu_wb_alu", wb_alu, 32'h3);
        check_eq("alu_wb_rd", wb_rd, 7);
        check_eq("alu_wb_rw", wb_rw, 1);
        check_eq("alu_wb_rdata", wb_rdata, 0);

        // Load at 0x10, ack on the third ACCESS cycle.
        tick();
        set_ex(1, 1, 0, 1, 1, 32'h10, 0, 5'd3);
        @(negedge clk);
        check_eq("ld_issue_stall", stall, 1);
        check_eq("ld_issue_req", bus.dmem_req, 0);
        tick();
        @(negedge clk);
        check_eq("ld_a1_req", bus.dmem_req, 1);
        check_eq("ld_a1_addr", bus.dmem_addr, 32'h10);
        check_eq("ld_a1_we", bus.dmem_we, 0);
        check_eq("ld_a1_stall", stall, 1);
        check_eq("ld_a1_wb_valid", wb_valid, 0);
        tick();
        @(negedge clk);
        check_eq("ld_a2_stall", stall, 1);
        check_eq("ld_a2_addr", bus.dmem_addr, 32'h10);
        tick();
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'h5;
        @(negedge clk);
        check_eq("ld_ack_stall", stall, 0);
        tick();
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = 32'hFFFF_FFFF;
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_eq("ld_wb_rdata", wb_rdata, 32'h5);
        check_eq("ld_wb_m2r", wb_m2r, 1);
        check_eq("ld_wb_rw", wb_rw, 1);
        check_eq("ld_wb_rd", wb_rd, 3);
        check_eq("ld_wb_valid", wb_valid, 1);
        check_eq("ld_done_req", bus.dmem_req, 0);

        // Store at 0x20, ack on the first ACCESS cycle.
        tick();
        set_ex(1, 0, 1, 0, 0, 32'h20, 32'hDEAD_BEEF, 5'd0);
        @(negedge clk);
        check_eq("st_issue_stall", stall, 1);
        tick();
        bus.dmem_ack = 1'b1;
        @(negedge clk);
        check_eq("st_req", bus.dmem_req, 1);
        check_eq("st_we", bus.dmem_we, 1);
        check_eq("st_wdata", bus.dmem_wdata, 32'hDEAD_BEEF);
        check_eq("st_ack_stall", stall, 0);
        tick();
        bus.dmem_ack = 1'b0;
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_eq("st_done_req", bus.dmem_req, 0);
        check_eq("st_wb_valid", wb_valid, 1);
        check_eq("st_wb_rw", wb_rw, 0);
        check_eq("st_wb_rdata", wb_rdata, 0);

        // Misaligned load: no request, error, bubble.
        tick();
        set_ex(1, 1, 0, 1, 1, 32'h13, 0, 5'd4);
        @(negedge clk);
        check_eq("mis_req", bus.dmem_req, 0);
        check_eq("mis_stall", stall, 0);
        check_eq("mis_err_before", err, 0);
        tick();
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_eq("mis_err", err, 1);
        check_eq("mis_wb_valid", wb_valid, 0);
        check_eq("mis_wb_rw", wb_rw, 0);
        check_eq("mis_req_after", bus.dmem_req, 0);

        // Clear the sticky error, then let a load time out.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("to_err_cleared", err, 0);
        tick();
        set_ex(1, 1, 0, 1, 1, 32'h40, 0, 5'd6);
        @(negedge clk);
        check_eq("to_issue_stall", stall, 1);
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            @(negedge clk);
            if (bus.dmem_req) req_cycles++;
            if (!stall) break;
        end
        check_eq("to_req_cycles", req_cycles, 16);
        check_eq("to_last_req", bus.dmem_req, 1);
        tick();
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_eq("to_req_drop", bus.dmem_req, 0);
        check_eq("to_err", err, 1);
        check_eq("to_wb_valid", wb_valid, 1);
        check_eq("to_wb_rw", wb_rw, 0);

        // Reset on the second ACCESS cycle; the late ack must be ignored.
        tick();
        set_ex(1, 1, 0, 1, 1, 32'h50, 0, 5'd9);
        @(negedge clk);
        check_eq("ra_issue_stall", stall, 1);
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_eq("ra_rst_stall", stall, 0);
        tick();
        rst = 1'b0;
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'h99;
        @(negedge clk);
        check_eq("ra_req", bus.dmem_req, 0);
        check_eq("ra_err", err, 0);
        check_eq("ra_wb_valid", wb_valid, 0);
        check_eq("ra_wb_rw", wb_rw, 0);
        tick();
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        check_eq("ra_late_wb_valid", wb_valid, 0);
        check_eq("ra_late_wb_rdata", wb_rdata, 0);
        check_eq("ra_late_req", bus.dmem_req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
